// File: rtl/barrett_reduce_pipe_pkg.sv
// Shared types and widths for the Barrett reduction pipeline.
// W comes from `W_BITS and N from `N_SLOTS; defaults are applied when they are undefined.
`ifndef W_BITS
`define W_BITS 16
`endif
`ifndef N_SLOTS
`define N_SLOTS 4
`endif

package barrett_reduce_pipe_pkg;
   localparam int unsigned W  = `W_BITS;
   localparam int unsigned N  = `N_SLOTS;
   localparam int unsigned WW = 2 * W + 1;

   typedef logic [W-1:0]     word_t;
   typedef logic [WW-1:0]    wide_word_t;
   typedef logic [W:0]       barrett_mu_t;
   typedef word_t      [N-1:0] vec_t;
   typedef wide_word_t [N-1:0] wide_vec_t;

   // The low W+2 bits are enough to carry x - qh*q, because that difference is below 3q < 2^(W+2).
   typedef logic [W+1:0]     rem_t;
   typedef logic [2*W+2:0]   prod_t;
endpackage

// File: rtl/barrett_reduce_pipe_lane.sv
// One lane of the Barrett reduction datapath.
// The lane has three enabled register stages: the estimate product, then qh*q, then the corrected residue.
module barrett_lane
   import barrett_reduce_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  wide_word_t  x,
   input  word_t       q,
   input  barrett_mu_t mu,
`ifdef BARRETT_OVF_CHECK_EN
   output logic        x_over,
`endif
   output word_t       r
);
   rem_t  x1_d, x1_q, t1h_d, t1h_q;
   word_t q1_d, q1_q;
   rem_t  x2_d, x2_q, p2_d, p2_q;
   word_t q2_d, q2_q;
   word_t r_d, r_q;
   rem_t  diff, two_q, red;

`ifdef BARRETT_OVF_CHECK_EN
   wide_word_t q_sq;

   always_comb begin
      q_sq   = wide_word_t'(q) * wide_word_t'(q);
      x_over = (x >= q_sq);
   end
`endif

   // Only the bits of t1 above W+1 matter downstream, so the shift is folded into stage 1.
   always_comb begin
      x1_d  = en ? x[W+1:0] : x1_q;
      q1_d  = en ? q : q1_q;
      t1h_d = en ? rem_t'((prod_t'(x[WW-1:W-1]) * prod_t'(mu)) >> (W + 1)) : t1h_q;
   end

   always_comb begin
      x2_d = en ? x1_q : x2_q;
      q2_d = en ? q1_q : q2_q;
      p2_d = en ? t1h_q * rem_t'(q1_q) : p2_q;
   end

   always_comb begin
      diff  = x2_q - p2_q;
      two_q = {1'b0, q2_q, 1'b0};
      red   = diff;
      if (diff >= two_q) begin
         red = diff - two_q;
      end else if (diff >= rem_t'(q2_q)) begin
         red = diff - rem_t'(q2_q);
      end
      r_d = en ? red[W-1:0] : r_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x1_q  <= '0;
         q1_q  <= '0;
         t1h_q <= '0;
         x2_q  <= '0;
         q2_q  <= '0;
         p2_q  <= '0;
         r_q   <= '0;
      end else begin
         x1_q  <= x1_d;
         q1_q  <= q1_d;
         t1h_q <= t1h_d;
         x2_q  <= x2_d;
         q2_q  <= q2_d;
         p2_q  <= p2_d;
         r_q   <= r_d;
      end
   end

   assign r = r_q;
endmodule

// File: rtl/barrett_reduce_pipe.sv
// Top level of the lane-wise Barrett reduction pipeline: 3 stages with valid/ready on both sides.
// Defining BARRETT_OVF_CHECK_EN adds a sticky ovf_err output that flags input lanes with x >= q*q.
module barrett_reduce_pipe
   import barrett_reduce_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  wide_vec_t   in_data,
   input  word_t       q,
   input  barrett_mu_t mu,
   output logic        out_valid,
   input  logic        out_ready,
   output vec_t        out_data
`ifdef BARRETT_OVF_CHECK_EN
   ,
   output logic        ovf_err
`endif
);
   logic adv;
   logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

   // The whole pipe, bubbles included, moves only when the output register is free.
   assign adv       = !v3_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = v3_q;

`ifdef BARRETT_OVF_CHECK_EN
   logic [N-1:0] lane_over;
   logic o1_d, o1_q, o2_d, o2_q, ovf_err_d, ovf_err_q;
`endif

   for (genvar i = 0; i < N; i++) begin : g_lane
      barrett_lane u_lane (
         .clk    (clk),
         .reset  (reset),
         .en     (adv),
         .x      (in_data[i]),
         .q      (q),
         .mu     (mu),
`ifdef BARRETT_OVF_CHECK_EN
         .x_over (lane_over[i]),
`endif
         .r      (out_data[i])
      );
   end

   always_comb begin
      v1_d = adv ? in_valid : v1_q;
      v2_d = adv ? v1_q : v2_q;
      v3_d = adv ? v2_q : v3_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
      end
   end

`ifdef BARRETT_OVF_CHECK_EN
   // The flag follows its beat down the pipe, so ovf_err rises when that beat reaches the output.
   always_comb begin
      o1_d      = adv ? (in_valid && (|lane_over)) : o1_q;
      o2_d      = adv ? o1_q : o2_q;
      ovf_err_d = ovf_err_q || (adv && o2_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o1_q      <= 1'b0;
         o2_q      <= 1'b0;
         ovf_err_q <= 1'b0;
      end else begin
         o1_q      <= o1_d;
         o2_q      <= o2_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   assign ovf_err = ovf_err_q;
`endif
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Self-checking bench for barrett_reduce_pipe: table vectors, random streams, stalls, reset and modulus changes.
module tb_barrett_reduce_pipe;
   import barrett_reduce_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   wide_vec_t   in_data = '0;
   word_t       q = '0;
   barrett_mu_t mu = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   vec_t        out_data;
`ifdef BARRETT_OVF_CHECK_EN
   logic        ovf_err;
`endif

   int unsigned chk_cnt = 0;
   int unsigned pass_cnt = 0;

   typedef struct {
      vec_t v;
      bit   dc;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      wide_vec_t   x;
      word_t       q;
      barrett_mu_t mu;
      vec_t        exp;
   } rec_t;
   rec_t tbl[4];

   always #5 clk = ~clk;

   barrett_reduce_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .q         (q),
      .mu        (mu),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef BARRETT_OVF_CHECK_EN
      ,
      .ovf_err   (ovf_err)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic wide_vec_t mkw(input longint unsigned a, b, c, d);
      wide_vec_t v;
      v = '0;
      v[0] = wide_word_t'(a);
      v[1] = wide_word_t'(b);
      v[2] = wide_word_t'(c);
      v[3] = wide_word_t'(d);
      return v;
   endfunction

   function automatic vec_t mkv(input longint unsigned a, b, c, d);
      vec_t v;
      v = '0;
      v[0] = word_t'(a);
      v[1] = word_t'(b);
      v[2] = word_t'(c);
      v[3] = word_t'(d);
      return v;
   endfunction

   function automatic barrett_mu_t calc_mu(input word_t qv);
      return barrett_mu_t'((64'd1 << (2 * W)) / 64'(qv));
   endfunction

   function automatic word_t rand_mod();
      return word_t'($urandom_range(2 ** W - 1, 2 ** (W - 1) + 1));
   endfunction

   task automatic gen_beat(input word_t qv);
      logic [63:0] rnd, qq;
      q  = qv;
      mu = calc_mu(qv);
      qq = 64'(qv) * 64'(qv);
      for (int j = 0; j < int'(N); j++) begin
         rnd = {$urandom(), $urandom()};
         in_data[j] = wide_word_t'(rnd % qq);
      end
   endtask

   // Reference model: each accepted beat's residues are x mod q for its own q.
   always @(negedge clk) begin
      exp_t e;
      if (reset && in_valid && in_ready) begin
         e.dc = 1'b0;
         for (int j = 0; j < int'(N); j++) begin
            e.v[j] = word_t'(64'(in_data[j]) % 64'(q));
            if (64'(in_data[j]) >= 64'(q) * 64'(q)) e.dc = 1'b1;
         end
         exp_q.push_back(e);
      end
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            if (!e.dc)
               for (int j = 0; j < int'(N); j++)
                  check($sformatf("stream_lane%0d", j), 64'(out_data[j]), 64'(e.v[j]));
         end
      end
   end

   task automatic apply_one(input int idx);
      @(posedge clk); #1;
      in_data  = tbl[idx].x;
      q        = tbl[idx].q;
      mu       = tbl[idx].mu;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1 check($sformatf("tbl%0d_in_ready", idx), 64'(in_ready), 64'(1));
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 check($sformatf("tbl%0d_early_valid", idx), 64'(out_valid), 64'(0));
      @(posedge clk); #1 check($sformatf("tbl%0d_valid", idx), 64'(out_valid), 64'(1));
      for (int j = 0; j < int'(N); j++)
         check($sformatf("tbl%0d_lane%0d", idx, j), 64'(out_data[j]), 64'(tbl[idx].exp[j]));
      @(posedge clk); #1 check($sformatf("tbl%0d_valid_drop", idx), 64'(out_valid), 64'(0));
   endtask

   task automatic drive_stream(input int nbeats, input int stall_at, input int stall_len);
      int   sent = 0;
      int   cyc = 0;
      bit   need = 1'b1;
      bit   stall;
      vec_t held = '0;
      while (sent < nbeats && cyc < 400) begin
         @(posedge clk); #1;
         stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
         out_ready = !stall;
         if (need) gen_beat(rand_mod());
         in_valid = 1'b1;
         @(negedge clk);
         check("stream_in_ready", 64'(in_ready), 64'(!stall));
         if (stall) begin
            if (cyc == stall_at) held = out_data;
            else check("stall_hold", 64'(out_data), 64'(held));
         end
         need = in_ready;
         if (in_ready) sent++;
         cyc++;
      end
      check("stream_sent", 64'(sent), 64'(nbeats));
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
      #1 check(name, 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      tbl[0] = '{mkw(0, 40960, 40961, 1677721600), word_t'(40961), barrett_mu_t'(104855),
                 mkv(0, 40960, 0, 1)};
      tbl[1] = '{mkw(65521, 0, 65520, 1), word_t'(65521), barrett_mu_t'(65551),
                 mkv(0, 0, 65520, 1)};
      tbl[2] = '{mkw(1, 40962, 81922, 12345), word_t'(40961), barrett_mu_t'(104855),
                 mkv(1, 1, 0, 12345)};
      tbl[3] = '{mkw(1677803520, 81927, 1677762561, 100000), word_t'(40961), barrett_mu_t'(104855),
                 mkv(40960, 5, 1, 18078)};

      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef BARRETT_OVF_CHECK_EN
      check("rst_ovf_err", 64'(ovf_err), 64'(0));
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 4; i++) apply_one(i);

      drive_stream(20, -1, 0);
      drain("b2b_drain");

      drive_stream(20, 8, 5);
      drain("bp_drain");

      // Beat A under q=40961 immediately followed by beat B under q=65521.
      @(posedge clk); #1;
      gen_beat(word_t'(40961));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = tbl[1].x;
      q       = tbl[1].q;
      mu      = tbl[1].mu;
      @(posedge clk); #1 in_valid = 1'b0;
      drain("qchg_drain");

      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         gen_beat(word_t'(40961));
         in_valid = 1'b1;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      check("pre_reset_valid", 64'(out_valid), 64'(1));
      #1 reset = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_out_data", 64'(out_data), 64'(0));
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1 reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1 check("post_reset_empty", 64'(out_valid), 64'(0));
      end
      apply_one(3);

`ifdef BARRETT_OVF_CHECK_EN
      @(posedge clk); #1;
      in_data  = mkw(5, 1677803521, 7, 9);
      q        = word_t'(40961);
      mu       = barrett_mu_t'(104855);
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      check("ovf_not_yet_1", 64'(ovf_err), 64'(0));
      @(posedge clk); #1 check("ovf_not_yet_2", 64'(ovf_err), 64'(0));
      @(posedge clk); #1;
      check("ovf_beat_valid", 64'(out_valid), 64'(1));
      check("ovf_set", 64'(ovf_err), 64'(1));
      apply_one(2);
      check("ovf_sticky", 64'(ovf_err), 64'(1));
      #1 reset = 1'b0;
      #1 check("ovf_cleared", 64'(ovf_err), 64'(0));
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b1;
`endif

      drain("final_drain");
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/barrett_reduce_pipe.md
Name: barrett_reduce_pipe

Overview:
- Downstream stage of the lane-wise product multiplier.
- Consumes one wide_vec_t of N_SLOTS products (each 2W+1 bits) per beat and reduces every lane modulo q with Barrett reduction.
- Emits a vec_t of W-bit residues in [0, q).
- 3-stage pipeline, valid/ready on both sides, full throughput of one beat per cycle.

Parameters:
- W, `W_BITS, residue word width.
- N, `N_SLOTS, number of lanes.
- WW, 2*W+1, input lane width (matches wide_vec_t).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage accepts the beat this cycle.
- in_data  in  wide_vec_t (N x WW)  lane products x[i].
- q  in  W  modulus; 2^(W-1) < q < 2^W required.
- mu  in  W+1  Barrett constant floor(2^(2W)/q).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  vec_t (N x W)  residues x[i] mod q.
- ovf_err  out  1  sticky precondition flag (only with the optional feature).

Behaviour:
- Reset (reset==0, async): all stage valids=0, out_valid=0, out_data=0, ovf_err=0. A reset mid-operation drops every in-flight beat; no partial output.
- Handshake: adv = !out_valid || out_ready; in_ready = adv (combinational). The whole pipeline shifts when adv=1 and holds all registers when adv=0. Bubbles are also held; bubble collapse is not required.
- Input transfer: in_valid && in_ready.
- Output transfer: out_valid && out_ready.
- While out_valid=1 && out_ready=0: out_data stays stable.
- q and mu are captured with each beat and travel down the pipe, so a q/mu change between beats is legal.
- Latency: a beat accepted at cycle t appears on out_valid at t+3 if there are no stalls. Each stall cycle adds one cycle.
- Stage 1 (per lane): t1 = (x >> (W-1)) * mu, W+2 by W+1 bits, unsigned. Register x, t1, q.
- Stage 2: qh = t1 >> (W+1); p = qh * q. Register x, p, q.
- Stage 3:
  - r = (x - p) computed on the low W+2 bits; guaranteed r < 3q.
  - If r >= 2q, subtract 2q; else if r >= q, subtract q.
  - Register the low W bits to out_data.
- Arithmetic is unsigned only; no signed casts. The MSB (bit 2W) of each input lane is always 0 from the multiplier.
- Input precondition: x < q^2. Out-of-range x gives an unspecified residue; no hang, no X.
- Simultaneous in/out transfer at full pipe: both occur, no loss, order preserved.

Optional Feature:
- Macro: BARRETT_OVF_CHECK_EN.
- With the macro:
  - Stage 1 additionally compares x >= q*q per lane.
  - Any lane violating sets ovf_err, sticky until reset. It is set 3 cycles after the offending beat is accepted, in the same cycle that beat reaches out_valid.
  - Data behaviour is unchanged.
- Without the macro: no ovf_err port, no q*q multiplier.

Decomposition:
- Shared package/header (types.svh): vec_t, wide_vec_t, word_t, wide_word_t, and a new barrett_mu_t (W+1 bits).
- One natural sub-module: barrett_lane, the per-lane datapath for stages 1-3 with an enable input. It is instantiated N times under generate.
- The parent owns the valid pipeline, handshake and ovf_err.

Test Plan (W=16, q=40961, mu=104855):
- Single beat: lanes {0, 40960, 40961, 1677721600(=40960^2)}, out_ready=1 → 3 cycles later out_data {0, 40960, 0, 1}, out_valid for one cycle.
- Back-to-back: 20 random beats, in_valid held high, out_ready=1 → in_ready stays 1. Outputs match x mod q in order, one per cycle starting cycle 3.
- Backpressure: out_ready=0 for 5 cycles mid-stream → in_ready=0, out_data stable. After release, no beat is lost or duplicated.
- Reset mid-flight: assert reset with 3 beats in the pipe → out_valid=0 immediately, out_data=0. After deassert the pipe is empty; a new beat completes in 3 cycles.
- q change: beat A with q=40961, then beat B with q=65521, mu=65551 → each beat is reduced by its own modulus; x=65521 gives 0 under q=65521.
- With BARRETT_OVF_CHECK_EN: lane x=1677803521 (=q^2) → ovf_err=1, asserted 3 cycles after acceptance and held across later legal beats until reset.
